// File: rtl/bitmode_addr_gen_pkg.sv
// Shared types and constants for the bitmap-mode pixel address generator.
// Holds FSM encodings, default widths, step direction constants and the per-axis control decode.
package bitmode_addr_gen_pkg;

    localparam int unsigned BM_XW_DEFAULT = 8;
    localparam int unsigned BM_YW_DEFAULT = 8;
    localparam int unsigned BM_BUS_W      = 8;

    // Polarity of the XINCn/YINCn controls.
    localparam logic BM_STEP_UP   = 1'b0;
    localparam logic BM_STEP_DOWN = 1'b1;

    typedef enum logic {
        BM_IDLE   = 1'b0,
        BM_ACCESS = 1'b1
    } bm_state_e;

    // Per-axis command for one clock edge.
    typedef struct packed {
        logic load;
        logic step;
        logic down;
    } bm_axis_ctrl_t;

    // A load on the same edge as a step suppresses that axis' step.
    function automatic bm_axis_ctrl_t bm_axis_ctrl(
        input logic ldn,
        input logic step_edge,
        input logic an,
        input logic incn
    );
        bm_axis_ctrl_t c;
        c.load = ~ldn;
        c.step = step_edge & ~an & ldn;
        c.down = (incn == BM_STEP_DOWN);
        return c;
    endfunction

endpackage

// File: rtl/bitmode_addr_gen_axis_counter.sv
// Single pixel-pointer axis: parallel load, optional up/down step, modulo 2^W wrap.
// Load has priority over step.
module bitmode_addr_gen_axis_counter
    import bitmode_addr_gen_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  bm_axis_ctrl_t ctrl,
    input  logic [W-1:0]  load_val,
    output logic [W-1:0]  count
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (ctrl.load) begin
            count <= load_val;
        end else if (ctrl.step) begin
            count <= ctrl.down ? (count - W'(1)) : (count + W'(1));
        end
    end

endmodule

// File: rtl/bitmode_addr_gen.sv
// Bitmap-mode pixel address generator: CPU-loaded X/Y pointers stepped once per bitmap access.
// Optional pointer readback enabled with the BITMODE_RDBACK_EN macro.
module bitmode_addr_gen
    import bitmode_addr_gen_pkg::*;
#(
    parameter int unsigned XW = BM_XW_DEFAULT,
    parameter int unsigned YW = BM_YW_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  XLDn,
    input  logic                  YLDn,
    input  logic [BM_BUS_W-1:0]   BD,
    input  logic                  BITMDn,
    input  logic                  AXn,
    input  logic                  AYn,
    input  logic                  XINCn,
    input  logic                  YINCn,
    output logic [XW-1:0]         BX,
    output logic [YW-1:0]         BY,
    output logic [XW+YW-2:0]      VA,
    output logic                  PIXSEL,
    output logic [BM_BUS_W-1:0]   RDDATA
);

    bm_state_e     state;
    bm_state_e     state_nxt;
    logic          step_edge;
    bm_axis_ctrl_t x_ctrl;
    bm_axis_ctrl_t y_ctrl;

    // Access tracking state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= BM_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Step fires on the edge that samples the end of an access.
    always_comb begin
        state_nxt = state;
        step_edge = 1'b0;
        case (state)
            BM_IDLE: begin
                if (!BITMDn) begin
                    state_nxt = BM_ACCESS;
                end
            end
            BM_ACCESS: begin
                if (BITMDn) begin
                    state_nxt = BM_IDLE;
                    step_edge = 1'b1;
                end
            end
            default: begin
                state_nxt = BM_IDLE;
            end
        endcase
    end

    assign x_ctrl = bm_axis_ctrl(XLDn, step_edge, AXn, XINCn);
    assign y_ctrl = bm_axis_ctrl(YLDn, step_edge, AYn, YINCn);

    bitmode_addr_gen_axis_counter #(
        .W (XW)
    ) u_x_axis (
        .clk      (clk),
        .reset_n  (reset_n),
        .ctrl     (x_ctrl),
        .load_val (XW'(BD)),
        .count    (BX)
    );

    bitmode_addr_gen_axis_counter #(
        .W (YW)
    ) u_y_axis (
        .clk      (clk),
        .reset_n  (reset_n),
        .ctrl     (y_ctrl),
        .load_val (YW'(BD)),
        .count    (BY)
    );

    // Two pixels per video RAM word; BX[0] picks the nibble.
    assign VA     = {BY, BX[XW-1:1]};
    assign PIXSEL = BX[0];

`ifdef BITMODE_RDBACK_EN
    logic last_x;

    // Remember which axis the CPU loaded last; reset points at X.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_x <= 1'b1;
        end else if (!YLDn) begin
            last_x <= 1'b0;
        end else if (!XLDn) begin
            last_x <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            RDDATA <= '0;
        end else if (BITMDn && last_x) begin
            RDDATA <= BM_BUS_W'(BX);
        end else begin
            RDDATA <= BM_BUS_W'(BY);
        end
    end
`else
    assign RDDATA = '0;
`endif

endmodule

// File: tb/tb_bitmode_addr_gen.sv
// Self-checking bench for bitmode_addr_gen: scoreboard of expected pointer/address state.
// Build with BITMODE_RDBACK_EN defined to exercise pointer readback.
module tb_bitmode_addr_gen;

    logic        clk;
    logic        reset_n;
    logic        XLDn, YLDn;
    logic [7:0]  BD;
    logic        BITMDn, AXn, AYn, XINCn, YINCn;
    logic [7:0]  BX, BY;
    logic [14:0] VA;
    logic        PIXSEL;
    logic [7:0]  RDDATA;

    typedef struct {
        string       name;
        logic [7:0]  bx;
        logic [7:0]  by;
        logic [14:0] va;
        logic        pix;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          n_checks = 0;
    int          n_err    = 0;
    logic [7:0]  mbx, mby;

    bitmode_addr_gen #(.XW(8), .YW(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .XLDn    (XLDn),
        .YLDn    (YLDn),
        .BD      (BD),
        .BITMDn  (BITMDn),
        .AXn     (AXn),
        .AYn     (AYn),
        .XINCn   (XINCn),
        .YINCn   (YINCn),
        .BX      (BX),
        .BY      (BY),
        .VA      (VA),
        .PIXSEL  (PIXSEL),
        .RDDATA  (RDDATA)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input string n, input logic [7:0] bx, input logic [7:0] by);
        exp_t r;
        r.name = n;
        r.bx   = bx;
        r.by   = by;
        r.va   = {by, bx[7:1]};
        r.pix  = bx[0];
        return r;
    endfunction

    function automatic logic [7:0] step8(input logic [7:0] v, input logic en, input logic dn);
        if (!en) return v;
        return dn ? v - 8'd1 : v + 8'd1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_xy(input logic ldx, input logic ldy, input logic [7:0] v);
        XLDn = ~ldx;
        YLDn = ~ldy;
        BD   = v;
        tick();
        XLDn = 1'b1;
        YLDn = 1'b1;
        if (ldx) mbx = v;
        if (ldy) mby = v;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        XLDn = 1'b1; YLDn = 1'b1; BD = 8'h00; BITMDn = 1'b1;
        AXn = 1'b1; AYn = 1'b1; XINCn = 1'b0; YINCn = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        tick();
        mbx = 8'h00; mby = 8'h00;
        n_checks++;
        if (BX !== 8'h00 || BY !== 8'h00 || VA !== 15'h0 || PIXSEL !== 1'b0 || RDDATA !== 8'h00) begin
            n_err++;
            $display("FAIL reset_state: BX=%h BY=%h VA=%h PIX=%b RD=%h expected all zero", BX, BY, VA, PIXSEL, RDDATA);
        end
        // Reset arriving in the middle of an access must drop the pending step.
        load_xy(1'b1, 1'b0, 8'h12);
        AXn = 1'b0;
        BITMDn = 1'b0;
        tick(); tick();
        #1 reset_n = 1'b0;
        #1;
        sb.push_back(mk("reset_async", 8'h00, 8'h00));
        e = sb.pop_front();
        n_checks++;
        if (BX !== e.bx || BY !== e.by) begin
            n_err++;
            $display("FAIL %s: BX=%h BY=%h expected BX=%h BY=%h", e.name, BX, BY, e.bx, e.by);
        end
        BITMDn = 1'b1;
        tick();
        reset_n = 1'b1;
        tick(); tick();
        mbx = 8'h00; mby = 8'h00;
        sb.push_back(mk("reset_no_step", mbx, mby));
        e = sb.pop_front();
        n_checks++;
        if (BX !== e.bx || BY !== e.by || VA !== e.va) begin
            n_err++;
            $display("FAIL %s: BX=%h BY=%h VA=%h expected BX=%h BY=%h VA=%h", e.name, BX, BY, VA, e.bx, e.by, e.va);
        end
        AXn = 1'b1;
    endtask

    task automatic test_step();
        int lens[3] = '{1, 4, 10};
        load_xy(1'b1, 1'b1, 8'h40);
        load_xy(1'b0, 1'b1, 8'h10);
        AXn = 1'b0; XINCn = 1'b0; AYn = 1'b1;
        foreach (lens[i]) begin
            BITMDn = 1'b0;
            repeat (lens[i]) tick();
            sb.push_back(mk($sformatf("step_hold%0d", i), mbx, mby));
            e = sb.pop_front();
            n_checks++;
            if (BX !== e.bx || BY !== e.by || VA !== e.va) begin
                n_err++;
                $display("FAIL %s: BX=%h BY=%h VA=%h expected BX=%h BY=%h VA=%h", e.name, BX, BY, VA, e.bx, e.by, e.va);
            end
            BITMDn = 1'b1;
            tick();
            mbx = step8(mbx, 1'b1, 1'b0);
            sb.push_back(mk($sformatf("step_after%0d", i), mbx, mby));
            e = sb.pop_front();
            n_checks++;
            if (BX !== e.bx || BY !== e.by || VA !== e.va || PIXSEL !== e.pix) begin
                n_err++;
                $display("FAIL %s: BX=%h BY=%h VA=%h PIX=%b expected BX=%h BY=%h VA=%h PIX=%b",
                         e.name, BX, BY, VA, PIXSEL, e.bx, e.by, e.va, e.pix);
            end
            tick();
        end
    endtask

    task automatic test_wrap();
        load_xy(1'b1, 1'b0, 8'hFF);
        load_xy(1'b0, 1'b1, 8'h00);
        AXn = 1'b0; XINCn = 1'b0; AYn = 1'b0; YINCn = 1'b1;
        for (int k = 0; k < 2; k++) begin
            if (k == 1) begin
                load_xy(1'b1, 1'b0, 8'h00);
                XINCn = 1'b1; AYn = 1'b1;
            end
            BITMDn = 1'b0;
            tick();
            BITMDn = 1'b1;
            tick();
            mbx = step8(mbx, ~AXn, XINCn);
            mby = step8(mby, ~AYn, YINCn);
            sb.push_back(mk($sformatf("wrap%0d", k), mbx, mby));
            e = sb.pop_front();
            n_checks++;
            if (BX !== e.bx || BY !== e.by || VA !== e.va || PIXSEL !== e.pix) begin
                n_err++;
                $display("FAIL %s: BX=%h BY=%h VA=%h PIX=%b expected BX=%h BY=%h VA=%h PIX=%b",
                         e.name, BX, BY, VA, PIXSEL, e.bx, e.by, e.va, e.pix);
            end
        end
    endtask

    task automatic test_load_on_step();
        AXn = 1'b0; AYn = 1'b0; XINCn = 1'b0; YINCn = 1'b0;
        BITMDn = 1'b0;
        tick();
        BITMDn = 1'b1;
        XLDn = 1'b0;
        BD = 8'h80;
        tick();
        XLDn = 1'b1;
        mbx = 8'h80;
        mby = step8(mby, 1'b1, 1'b0);
        sb.push_back(mk("load_on_step", mbx, mby));
        e = sb.pop_front();
        n_checks++;
        if (BX !== e.bx || BY !== e.by || VA !== e.va) begin
            n_err++;
            $display("FAIL %s: BX=%h BY=%h VA=%h expected BX=%h BY=%h VA=%h", e.name, BX, BY, VA, e.bx, e.by, e.va);
        end
    endtask

    task automatic test_load_mid_access();
        AXn = 1'b0; XINCn = 1'b0; AYn = 1'b1;
        BITMDn = 1'b0;
        tick(); tick();
        XLDn = 1'b0;
        BD = 8'h20;
        tick();
        XLDn = 1'b1;
        mbx = 8'h20;
        tick();
        sb.push_back(mk("load_mid_hold", mbx, mby));
        BITMDn = 1'b1;
        e = sb.pop_front();
        n_checks++;
        if (BX !== e.bx || BY !== e.by) begin
            n_err++;
            $display("FAIL %s: BX=%h BY=%h expected BX=%h BY=%h", e.name, BX, BY, e.bx, e.by);
        end
        tick();
        mbx = step8(mbx, 1'b1, 1'b0);
        sb.push_back(mk("load_mid_after", mbx, mby));
        e = sb.pop_front();
        n_checks++;
        if (BX !== e.bx || BY !== e.by || VA !== e.va) begin
            n_err++;
            $display("FAIL %s: BX=%h BY=%h VA=%h expected BX=%h BY=%h VA=%h", e.name, BX, BY, VA, e.bx, e.by, e.va);
        end
    endtask

    task automatic test_rdback();
        logic [7:0] exp_rd;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) load_xy(1'b0, 1'b1, 8'h5A);
            else        load_xy(1'b1, 1'b0, 8'h33);
            tick();
`ifdef BITMODE_RDBACK_EN
            exp_rd = (k == 0) ? 8'h5A : 8'h33;
`else
            exp_rd = 8'h00;
`endif
            n_checks++;
            if (RDDATA !== exp_rd) begin
                n_err++;
                $display("FAIL rdback%0d: RDDATA=%h expected %h", k, RDDATA, exp_rd);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 8; k++) begin
            AXn   = 1'($urandom_range(0, 1));
            AYn   = 1'($urandom_range(0, 1));
            XINCn = 1'($urandom_range(0, 1));
            YINCn = 1'($urandom_range(0, 1));
            BITMDn = 1'b0;
            repeat ($urandom_range(1, 3)) tick();
            BITMDn = 1'b1;
            tick();
            mbx = step8(mbx, ~AXn, XINCn);
            mby = step8(mby, ~AYn, YINCn);
            sb.push_back(mk($sformatf("b2b%0d", k), mbx, mby));
            e = sb.pop_front();
            n_checks++;
            if (BX !== e.bx || BY !== e.by || VA !== e.va || PIXSEL !== e.pix) begin
                n_err++;
                $display("FAIL %s: BX=%h BY=%h VA=%h PIX=%b expected BX=%h BY=%h VA=%h PIX=%b",
                         e.name, BX, BY, VA, PIXSEL, e.bx, e.by, e.va, e.pix);
            end
        end
        AXn = 1'b1; AYn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_step();
        test_wrap();
        test_load_on_step();
        test_load_mid_access();
        test_rdback();
        test_back_to_back();
        tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
